// File: rtl/score_ctrl.sv
// Game-score sequencer for the two-tank arena: per-player scores with BCD digits,
// post-point pause counted in video frames, and match-end / draw detection.
module score_ctrl #(
    parameter int WIN_SCORE   = 10,
    parameter int HOLD_FRAMES = 120
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       hit_p1_i,
    input  logic       hit_p2_i,
    input  logic       frame_start_i,
    input  logic       new_game_i,
    output logic [5:0] score_player_1_o,
    output logic [5:0] score_player_2_o,
    output logic [3:0] p1_tens_o,
    output logic [3:0] p1_ones_o,
    output logic [3:0] p2_tens_o,
    output logic [3:0] p2_ones_o,
    output logic       freeze_o,
    output logic       round_over_o,
    output logic [1:0] winner_o
);

    localparam logic [5:0] WIN  = 6'(WIN_SCORE);
    localparam logic [7:0] HOLD = 8'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_HOLD,
        ST_OVER
    } state_t;

    typedef struct packed {
        logic [5:0] score;
        logic [3:0] tens;
        logic [3:0] ones;
    } player_t;

    state_t     state_q, state_d;
    player_t    p1_q, p1_d, p2_q, p2_d;
    player_t    p1_new, p2_new;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] winner_q, winner_d;
    logic       p1_win, p2_win;

    // Binary and BCD advance together, so the overlay never needs a divider.
    function automatic player_t inc_player(input player_t p);
        player_t r;
        r.score = p.score + 6'd1;
        if (p.ones == 4'd9) begin
            r.ones = 4'd0;
            r.tens = p.tens + 4'd1;
        end else begin
            r.ones = p.ones + 4'd1;
            r.tens = p.tens;
        end
        return r;
    endfunction

    always_comb begin
        p1_new = hit_p1_i ? inc_player(p1_q) : p1_q;
        p2_new = hit_p2_i ? inc_player(p2_q) : p2_q;
        p1_win = (p1_new.score == WIN);
        p2_win = (p2_new.score == WIN);
    end

    // NOTE: every signal driven here gets a default first, so no path leaves a latch.
    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        cnt_d    = cnt_q;
        winner_d = winner_q;

        case (state_q)
            ST_PLAY: begin
                if (hit_p1_i || hit_p2_i) begin
                    p1_d = p1_new;
                    p2_d = p2_new;
                    if (p1_win && p2_win) begin
                        state_d  = ST_OVER;
                        winner_d = 2'b11;
                    end else if (p1_win) begin
                        state_d  = ST_OVER;
                        winner_d = 2'b01;
                    end else if (p2_win) begin
                        state_d  = ST_OVER;
                        winner_d = 2'b10;
                    end else if (HOLD_FRAMES != 0) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (frame_start_i) begin
                    if (cnt_q <= 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_OVER: ;
            default: state_d = ST_PLAY;
        endcase

        // Restart wins over anything the state logic decided this cycle.
        if (new_game_i) begin
            p1_d     = '0;
            p2_d     = '0;
            winner_d = 2'b00;
            cnt_d    = HOLD;
            state_d  = (HOLD_FRAMES != 0) ? ST_HOLD : ST_PLAY;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_PLAY;
            p1_q     <= '0;
            p2_q     <= '0;
            cnt_q    <= '0;
            winner_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            cnt_q    <= cnt_d;
            winner_q <= winner_d;
        end
    end

    assign score_player_1_o = p1_q.score;
    assign score_player_2_o = p2_q.score;
    assign p1_tens_o        = p1_q.tens;
    assign p1_ones_o        = p1_q.ones;
    assign p2_tens_o        = p2_q.tens;
    assign p2_ones_o        = p2_q.ones;
    assign freeze_o         = (state_q != ST_PLAY);
    assign round_over_o     = (state_q == ST_OVER);
    assign winner_o         = winner_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl with WIN_SCORE = 12, HOLD_FRAMES = 3:
// a vector table for the first point/pause cycles, then hand-written match sequences.
module tb_score_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       hit_p1_i = 1'b0, hit_p2_i = 1'b0, frame_start_i = 1'b0, new_game_i = 1'b0;
    logic [5:0] score_player_1_o, score_player_2_o;
    logic [3:0] p1_tens_o, p1_ones_o, p2_tens_o, p2_ones_o;
    logic       freeze_o, round_over_o;
    logic [1:0] winner_o;

    int n_checks = 0;
    int n_fail   = 0;

    score_ctrl #(.WIN_SCORE(12), .HOLD_FRAMES(3)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .hit_p1_i         (hit_p1_i),
        .hit_p2_i         (hit_p2_i),
        .frame_start_i    (frame_start_i),
        .new_game_i       (new_game_i),
        .score_player_1_o (score_player_1_o),
        .score_player_2_o (score_player_2_o),
        .p1_tens_o        (p1_tens_o),
        .p1_ones_o        (p1_ones_o),
        .p2_tens_o        (p2_tens_o),
        .p2_ones_o        (p2_ones_o),
        .freeze_o         (freeze_o),
        .round_over_o     (round_over_o),
        .winner_o         (winner_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       h1, h2, fs, ng;
        logic [5:0] s1, s2;
        logic [3:0] p1o, p2o;
        logic       frz;
        logic [1:0] win;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic h1, input logic h2, input logic fs, input logic ng);
        @(negedge clk_i);
        hit_p1_i      = h1;
        hit_p2_i      = h2;
        frame_start_i = fs;
        new_game_i    = ng;
        @(posedge clk_i);
        #1;
        hit_p1_i      = 1'b0;
        hit_p2_i      = 1'b0;
        frame_start_i = 1'b0;
        new_game_i    = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // One point followed by a full pause, leaving the DUT back in PLAY.
    task automatic add_point(input logic h1, input logic h2);
        step(h1, h2, 1'b0, 1'b0);
        frames(3);
    endtask

    task automatic check_all(input string tag, input logic [5:0] s1, input logic [5:0] s2,
                             input logic [3:0] p1t, input logic [3:0] p1o,
                             input logic [3:0] p2t, input logic [3:0] p2o,
                             input logic frz, input logic ovr, input logic [1:0] win);
        check({tag, ".s1"},   32'(score_player_1_o), 32'(s1));
        check({tag, ".s2"},   32'(score_player_2_o), 32'(s2));
        check({tag, ".p1t"},  32'(p1_tens_o),        32'(p1t));
        check({tag, ".p1o"},  32'(p1_ones_o),        32'(p1o));
        check({tag, ".p2t"},  32'(p2_tens_o),        32'(p2t));
        check({tag, ".p2o"},  32'(p2_ones_o),        32'(p2o));
        check({tag, ".frz"},  32'(freeze_o),         32'(frz));
        check({tag, ".over"}, 32'(round_over_o),     32'(ovr));
        check({tag, ".win"},  32'(winner_o),         32'(win));
    endtask

    initial begin
        //           h1    h2    fs    ng    s1 s2 p1o p2o frz win
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1, 0, 1'b1, 2'd0}; // point, enter HOLD
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1, 0, 1'b1, 2'd0}; // 3 -> 2
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1, 0, 1'b1, 2'd0}; // hit in HOLD ignored
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1, 0, 1'b1, 2'd0}; // 2 -> 1
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1, 0, 1'b0, 2'd0}; // back to PLAY
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 1, 1, 1'b1, 2'd0}; // hit wins over frame
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 1, 1, 1'b1, 2'd0}; // full count: 3 -> 2
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 1, 1, 1'b1, 2'd0}; // 2 -> 1
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 1, 1, 1'b0, 2'd0}; // PLAY

        repeat (2) @(negedge clk_i);
        check_all("reset", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 2'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].h1, vecs[i].h2, vecs[i].fs, vecs[i].ng);
            check($sformatf("vec%0d.s1", i),  32'(score_player_1_o), 32'(vecs[i].s1));
            check($sformatf("vec%0d.s2", i),  32'(score_player_2_o), 32'(vecs[i].s2));
            check($sformatf("vec%0d.p1o", i), 32'(p1_ones_o),        32'(vecs[i].p1o));
            check($sformatf("vec%0d.p2o", i), 32'(p2_ones_o),        32'(vecs[i].p2o));
            check($sformatf("vec%0d.frz", i), 32'(freeze_o),         32'(vecs[i].frz));
            check($sformatf("vec%0d.win", i), 32'(winner_o),         32'(vecs[i].win));
            check($sformatf("vec%0d.ovr", i), 32'(round_over_o),     32'(0));
        end

        // Player 2 to 9, then the tens carry at 10.
        for (int i = 0; i < 8; i++) add_point(1'b0, 1'b1);
        check_all("p2_nine", 1, 9, 0, 1, 0, 9, 1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_all("p2_ten", 1, 10, 0, 1, 1, 0, 1'b1, 1'b0, 2'd0);
        frames(3);

        // 11:11, then both score together -> draw.
        add_point(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) add_point(1'b1, 1'b0);
        check_all("eleven_all", 11, 11, 1, 1, 1, 1, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("draw", 12, 12, 1, 2, 1, 2, 1'b1, 1'b1, 2'd3);
        frames(4);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("draw_hold", 12, 12, 1, 2, 1, 2, 1'b1, 1'b1, 2'd3);

        // Restart, then player 1 wins outright.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_all("new_game", 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 2'd0);
        frames(3);
        check("ng_pause_done", 32'(freeze_o), 32'(0));
        for (int i = 0; i < 12; i++) add_point(1'b1, 1'b0);
        check_all("p1_wins", 12, 0, 1, 2, 0, 0, 1'b1, 1'b1, 2'd1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_all("over_ignore", 12, 0, 1, 2, 0, 0, 1'b1, 1'b1, 2'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check_all("ng_prio", 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 2'd0);
        frames(1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("hold_ignore.s2", 32'(score_player_2_o), 32'(0));
        frames(2);
        check("hold_exit", 32'(freeze_o), 32'(0));

        // Reach 5:3 with the DUT mid-pause, then reset asynchronously.
        for (int i = 0; i < 5; i++) add_point(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) add_point(1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_all("pre_reset", 5, 3, 0, 5, 0, 3, 1'b1, 1'b0, 2'd0);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 2'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("post_reset", 1, 0, 0, 1, 0, 0, 1'b1, 1'b0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
